// File: rtl/tick_scheduler.sv
// tick_scheduler: shares one 2^DIVIDER-cycle tick divider between two requesters, round-robin.
// Define TICK_SCHEDULER_HALF_TICK_EN to build the mid-period half_tick pulse; otherwise it is tied low.
module tick_scheduler #(
   parameter int DIVIDER = 9,
   parameter int CNT_W   = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req0,
   input  logic             req1,
   input  logic [CNT_W-1:0] len0,
   input  logic [CNT_W-1:0] len1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             tick,
   output logic             half_tick,
   output logic             done0,
   output logic             done1,
   output logic             busy,
   output logic [1:0]       state_dbg
);

   // Handshake: reqN is a level held until doneN pulses, or dropped early to abort;
   // lenN is sampled only in the grant cycle; gnt, tick and done are registered outputs.
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [DIVIDER-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic               last_q, last_d;
   logic               pick, own_req, wrap;
   logic               gnt0_d, gnt1_d, tick_d, done0_d, done1_d, busy_d;

`ifdef TICK_SCHEDULER_HALF_TICK_EN
   localparam logic [DIVIDER-1:0] HALF_POINT = {1'b0, {(DIVIDER-1){1'b1}}};
   logic half_d;
`endif

   // last_q doubles as the grantee index once a grant is made.
   assign wrap      = (cnt_q == {DIVIDER{1'b1}});
   assign own_req   = last_q ? req1 : req0;
   assign pick      = (req0 & req1) ? ~last_q : req1;
   assign state_dbg = state_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      last_d  = last_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      tick_d  = 1'b0;
      done0_d = 1'b0;
      done1_d = 1'b0;
      busy_d  = 1'b0;
`ifdef TICK_SCHEDULER_HALF_TICK_EN
      half_d  = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               state_d = RUN;
               cnt_d   = '0;
               rem_d   = pick ? len1 : len0;
               last_d  = pick;
               gnt0_d  = ~pick;
               gnt1_d  = pick;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            // Abort wins over completion and over a tick due on this edge.
            if (!own_req) begin
               state_d = IDLE;
               cnt_d   = '0;
               rem_d   = '0;
            end else if (rem_q == '0) begin
               state_d = DONE;
               cnt_d   = '0;
               done0_d = ~last_q;
               done1_d = last_q;
            end else begin
               cnt_d  = cnt_q + 1'b1;
               gnt0_d = ~last_q;
               gnt1_d = last_q;
               busy_d = 1'b1;
               if (wrap) begin
                  tick_d = 1'b1;
                  rem_d  = rem_q - 1'b1;
               end
`ifdef TICK_SCHEDULER_HALF_TICK_EN
               half_d = (cnt_q == HALF_POINT);
`endif
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         last_q  <= 1'b1;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         tick    <= 1'b0;
         done0   <= 1'b0;
         done1   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         last_q  <= last_d;
         gnt0    <= gnt0_d;
         gnt1    <= gnt1_d;
         tick    <= tick_d;
         done0   <= done0_d;
         done1   <= done1_d;
         busy    <= busy_d;
      end
   end

`ifdef TICK_SCHEDULER_HALF_TICK_EN
   always_ff @(posedge clk) begin
      if (!rstn) half_tick <= 1'b0;
      else       half_tick <= half_d;
   end
`else
   assign half_tick = 1'b0;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler (DIVIDER=3): random episodes, event scoreboard fed by a timeline model.
module tb_tick_scheduler;
   localparam int DIVIDER = 3;
   localparam int CNT_W   = 4;
   localparam int P       = 8;
   localparam int W       = 24;
   localparam logic [2:0] K_RISE = 3'd0, K_HALF = 3'd1, K_TICK = 3'd2, K_FALL = 3'd3, K_DONE = 3'd4;

   logic clk = 1'b0, rstn = 1'b0, req0 = 1'b0, req1 = 1'b0;
   logic [CNT_W-1:0] len0 = '0, len1 = '0;
   logic gnt0, gnt1, tick, half_tick, done0, done1, busy;
   logic [1:0] state_dbg;

   tick_scheduler #(.DIVIDER(DIVIDER), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn), .req0(req0), .req1(req1), .len0(len0), .len1(len1),
      .gnt0(gnt0), .gnt1(gnt1), .tick(tick), .half_tick(half_tick),
      .done0(done0), .done1(done1), .busy(busy), .state_dbg(state_dbg)
   );

   // clock / reset / cycle count
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: cycle %0d reached, expected bench to finish earlier", cyc);
      $fatal(1, "watchdog expired");
   end

   // scoreboard
   logic [W-1:0] exp_q[$];
   int  vectors = 0, miscompares = 0;
   int  last_m = 1, free_c = 0;
   bit  mon_en = 1'b0;
   logic pg0 = 1'b0, pg1 = 1'b0;

   function automatic logic [W-1:0] item(logic [2:0] k, logic id, int c);
      return {k, id, 20'(c)};
   endfunction

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endfunction

   function automatic void push(logic [2:0] k, logic id, int c);
      exp_q.push_back(item(k, id, c));
   endfunction

   function automatic void observe(logic [2:0] k, logic id);
      logic [W-1:0] e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL unexpected_event: kind %0d id %0d at cycle %0d, expected nothing", k, id, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e !== item(k, id, cyc)) begin
            miscompares++;
            $display("FAIL event: got kind %0d id %0d cycle %0d, expected kind %0d id %0d cycle %0d",
                     k, id, cyc, e[23:21], e[20], e[19:0]);
         end
      end
   endfunction

   // monitor: pops the expected queue whenever the DUT shows an event
   always @(negedge clk) begin
      if (mon_en) begin
         while (exp_q.size() > 0 && int'(exp_q[0][19:0]) < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL missed_event: kind %0d id %0d expected at cycle %0d, not seen by cycle %0d",
                     exp_q[0][23:21], exp_q[0][20], exp_q[0][19:0], cyc);
            void'(exp_q.pop_front());
         end
         check("one_grant", {31'd0, gnt0 & gnt1}, 32'd0);
         check("busy_vs_gnt", {31'd0, busy}, {31'd0, gnt0 | gnt1});
`ifndef TICK_SCHEDULER_HALF_TICK_EN
         check("half_tick_off", {31'd0, half_tick}, 32'd0);
`endif
         if (gnt0 && !pg0) observe(K_RISE, 1'b0);
         if (gnt1 && !pg1) observe(K_RISE, 1'b1);
`ifdef TICK_SCHEDULER_HALF_TICK_EN
         if (half_tick) observe(K_HALF, gnt1);
`endif
         if (tick) observe(K_TICK, gnt1);
         if (!gnt0 && pg0) observe(K_FALL, 1'b0);
         if (!gnt1 && pg1) observe(K_FALL, 1'b1);
         if (done0) observe(K_DONE, 1'b0);
         if (done1) observe(K_DONE, 1'b1);
         pg0 = gnt0;
         pg1 = gnt1;
      end
   end

   // reference timeline: grant at g, ticks every P cycles, done one cycle after the last tick;
   // a stop (abort or reset) at cycle a keeps only events up to a and drops gnt at a+1.
   task automatic model_run(input int id, input int len, input int g, input int a, output int d);
      push(K_RISE, id[0], g);
      for (int k = 1; k <= len; k++) begin
`ifdef TICK_SCHEDULER_HALF_TICK_EN
         if (a < 0 || g + (k-1)*P + P/2 <= a) push(K_HALF, id[0], g + (k-1)*P + P/2);
`endif
         if (a < 0 || g + k*P <= a) push(K_TICK, id[0], g + k*P);
      end
      if (a < 0) begin
         d = g + len*P + 1;
         push(K_FALL, id[0], d);
         push(K_DONE, id[0], d);
      end else begin
         d = a + 1;
         push(K_FALL, id[0], d);
      end
      last_m = id;
   endtask

   // driver tasks
   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int start_cycle();
      return ((cyc > free_c) ? cyc : free_c) + int'($urandom_range(0, 3));
   endfunction

   task automatic set_req(input int id, input logic v);
      if (id == 1) req1 = v; else req0 = v;
   endtask

   task automatic set_len(input int id, input int v);
      if (id == 1) len1 = CNT_W'(v); else len0 = CNT_W'(v);
   endtask

   task automatic ep_single(input int id, input int len);
      int t, d;
      t = start_cycle();
      wait_until(t);
      set_len(id, len);
      set_req(id, 1'b1);
      model_run(id, len, t + 1, -1, d);
      wait_until(t + 1);
      set_len(id, int'($urandom_range(0, 15)));
      wait_until(d);
      set_req(id, 1'b0);
      free_c = d + 1;
   endtask

   task automatic ep_tie(input int l0, input int l1, input bit hold);
      int t, w, lo, d1, d2, d3;
      t = start_cycle();
      wait_until(t);
      len0 = CNT_W'(l0);
      len1 = CNT_W'(l1);
      req0 = 1'b1;
      req1 = 1'b1;
      w  = 1 - last_m;
      lo = 1 - w;
      model_run(w, (w == 1) ? l1 : l0, t + 1, -1, d1);
      model_run(lo, (lo == 1) ? l1 : l0, d1 + 2, -1, d2);
      d3 = d2;
      if (hold) model_run(w, (w == 1) ? l1 : l0, d2 + 2, -1, d3);
      wait_until(d1);
      if (!hold) set_req(w, 1'b0);
      wait_until(d2);
      set_req(lo, 1'b0);
      wait_until(d3);
      set_req(w, 1'b0);
      free_c = d3 + 1;
   endtask

   task automatic ep_abort(input int id, input int len, input int n, input int r, input bit pend);
      int t, a, d, d2, ol;
      t  = start_cycle();
      ol = int'($urandom_range(0, 4));
      wait_until(t);
      set_len(id, len);
      set_len(1 - id, ol);
      set_req(id, 1'b1);
      a = t + 1 + n*P + r;
      model_run(id, len, t + 1, a, d);
      d2 = d;
      if (pend) model_run(1 - id, ol, a + 2, -1, d2);
      wait_until(t + 1);
      if (pend) set_req(1 - id, 1'b1);
      wait_until(a);
      set_req(id, 1'b0);
      wait_until(d2);
      set_req(1 - id, 1'b0);
      free_c = d2 + 1;
   endtask

   task automatic ep_reset(input int id, input int len, input int n, input int r);
      int t, a, d;
      t = start_cycle();
      wait_until(t);
      set_len(id, len);
      set_req(id, 1'b1);
      a = t + 1 + n*P + r;
      model_run(id, len, t + 1, a, d);
      wait_until(a);
      rstn = 1'b0;
      set_req(id, 1'b0);
      wait_until(a + 1);
      check("reset_mid_run_outputs", {25'd0, gnt0, gnt1, busy, tick, half_tick, done0, done1}, 32'd0);
      rstn   = 1'b1;
      last_m = 1;
      free_c = a + 1;
   endtask

   // main sequence
   initial begin
      int id, len;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {25'd0, gnt0, gnt1, busy, tick, half_tick, done0, done1}, 32'd0);
      rstn   = 1'b1;
      free_c = cyc;
      mon_en = 1'b1;

      ep_tie(1, 1, 1'b1);
      ep_single(0, 3);
      ep_single(1, 0);
      ep_abort(0, 5, 2, 0, 1'b1);
      ep_reset(0, 4, 1, 3);
      ep_tie(2, 1, 1'b0);
      ep_single(0, 2);

      for (int i = 0; i < 30; i++) begin
         id  = int'($urandom_range(0, 1));
         len = int'($urandom_range(1, 6));
         case ($urandom_range(0, 4))
            0: ep_single(id, int'($urandom_range(0, 6)));
            1: ep_tie(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
            2: ep_abort(id, len, int'($urandom_range(0, len - 1)), int'($urandom_range(0, P - 1)),
                        1'($urandom_range(0, 1)));
            3: ep_single(id, 0);
            default: ep_reset(id, len, int'($urandom_range(0, len - 1)), int'($urandom_range(0, P - 1)));
         endcase
      end

      wait_until(cyc + 20);
      check("queue_drained", exp_q.size(), 32'd0);
      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
